// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the fetch/PC unit
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef logic [XLEN-1:0] word_t;
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;
  localparam word_t RESET_PC_DEF = 32'h0000_0000;
  localparam word_t TRAP_VEC_DEF = 32'h0000_0100;
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: combinational next-PC arithmetic (pc+4 or base+offset with bit0 cleared)
//   in : pc_i, base_i, offset_i, taken_i
//   out: next_pc_o (bit0 cleared when taken), misaligned_o (taken and target bit1 set)
module branch_target_adder
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic            taken_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);
  word_t sum, target;
  always_comb begin
    sum = base_i + offset_i;
    target = {sum[XLEN-1:1], 1'b0};
    next_pc_o = taken_i ? target : pc_i + XLEN'(INSTR_BYTES);
    misaligned_o = taken_i & target[1];
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter owner with a two-state fetch/execute sequencer
//   imem_req/imem_addr/imem_ready/imem_data : instruction memory handshake
//   instr/instr_addr/instr_valid            : latched instruction for decode (valid in EXEC)
//   commit/branch_taken/branch_base/offset  : retire and next-PC selection
//   trap                                    : one-cycle misaligned-target pulse
//   FETCH_MISALIGN_TRAP_EN : redirect misaligned taken targets to TRAP_VEC and pulse trap;
//                            otherwise the target is silently realigned and trap is tied 0
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
`ifdef FETCH_MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
`endif
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_addr,
  output logic            instr_valid,
  input  logic            commit,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_base,
  input  logic [XLEN-1:0] branch_offset,
  output logic            trap
);
  logic [0:0] state_q, state_d;
  word_t pc_q, pc_d, instr_q, instr_d, next_pc, redirect_pc;
  logic misaligned, retire, fetch_done;
  branch_target_adder u_bta (
    .pc_i        (pc_q),
    .base_i      (branch_base),
    .offset_i    (branch_offset),
    .taken_i     (branch_taken),
    .next_pc_o   (next_pc),
    .misaligned_o(misaligned)
  );
  assign fetch_done = state_q == FETCH && imem_ready;
  assign retire = state_q == EXEC && commit;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign redirect_pc = misaligned ? TRAP_VEC : next_pc;
  assign trap_d = retire & misaligned;
  always_ff @(posedge clk) trap_q <= reset ? 1'b0 : trap_d;
  assign trap = trap_q;
`else
  assign redirect_pc = misaligned ? {next_pc[XLEN-1:2], 2'b00} : next_pc;
  assign trap = 1'b0;
`endif
  assign state_d = fetch_done ? EXEC : retire ? FETCH : state_q;
  assign instr_d = fetch_done ? imem_data : instr_q;
  assign pc_d = retire ? redirect_pc : pc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
    end
  end
  // reset gates the handshake combinationally so an in-flight request drops in the reset cycle
  assign imem_req = ~reset & (state_q == FETCH);
  assign instr_valid = ~reset & (state_q == EXEC);
  assign imem_addr = pc_q;
  assign instr_addr = pc_q;
  assign instr = instr_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: randomized and directed checks of fetch_pc_unit against a transaction-level model
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_ready = 1'b0, commit = 1'b0, branch_taken = 1'b0;
  logic [31:0] imem_data = '0, branch_base = '0, branch_offset = '0;
  logic imem_req, instr_valid, trap;
  logic [31:0] imem_addr, instr, instr_addr;
  int checks = 0, errors = 0;
  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .instr(instr), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .commit(commit), .branch_taken(branch_taken),
    .branch_base(branch_base), .branch_offset(branch_offset), .trap(trap)
  );
  always #5 clk = ~clk;
  bit m_fetching = 1'b1, m_trap = 1'b0;
  logic [31:0] m_pc = RST_PC, m_instr = '0;
  function automatic logic [31:0] target_of(input logic [31:0] b, input logic [31:0] o);
    return (b + o) & ~32'h1;
  endfunction
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic tk, input logic [31:0] b, input logic [31:0] o);
    logic [31:0] t = target_of(b, o);
    if (!tk) return pc + 32'd4;
    if (t[1]) return TRAP_EN ? TVEC : t & ~32'h3;
    return t;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_fetching <= 1'b1; m_pc <= RST_PC; m_instr <= '0; m_trap <= 1'b0;
    end else begin
      m_trap <= TRAP_EN && !m_fetching && commit && branch_taken && target_of(branch_base, branch_offset)[1];
      if (m_fetching && imem_ready) begin
        m_instr <= imem_data; m_fetching <= 1'b0;
      end else if (!m_fetching && commit) begin
        m_pc <= model_next(m_pc, branch_taken, branch_base, branch_offset); m_fetching <= 1'b1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("imem_req", {31'd0, imem_req}, {31'd0, !reset && m_fetching});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, !reset && !m_fetching});
    chk("trap", {31'd0, trap}, {31'd0, m_trap});
    if (!reset && m_fetching) chk("imem_addr", imem_addr, m_pc);
    if (!reset && !m_fetching) begin
      chk("instr", instr, m_instr);
      chk("instr_addr", instr_addr, m_pc);
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic do_fetch(input int d, input logic [31:0] w);
    imem_ready = 1'b0;
    repeat (d) begin
      commit = 1'($urandom); imem_data = $urandom; step();
    end
    imem_ready = 1'b1; imem_data = w; commit = 1'($urandom); step();
    imem_ready = 1'b0; commit = 1'b0; imem_data = $urandom;
  endtask
  task automatic do_exec(input int d, input logic tk, input logic [31:0] b, input logic [31:0] o);
    commit = 1'b0;
    repeat (d) begin
      imem_ready = 1'($urandom); branch_base = $urandom; branch_taken = 1'($urandom); step();
    end
    commit = 1'b1; branch_taken = tk; branch_base = b; branch_offset = o; imem_ready = 1'($urandom); step();
    commit = 1'b0; imem_ready = 1'b0; branch_base = $urandom; branch_offset = $urandom;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) step();
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0; #1;
    chk("post_reset_req", {31'd0, imem_req}, 32'd1);
    chk("post_reset_addr", imem_addr, 32'h0);
    for (int i = 0; i < 2; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      do_fetch(0, 32'h1000 + 32'(i));
      chk("seq_valid", {31'd0, instr_valid}, 32'd1);
      do_exec(0, 1'b0, '0, '0);
    end
    chk("slow_addr", imem_addr, 32'h8);
    imem_ready = 1'b0; imem_data = 32'hDEAD_BEEF;
    repeat (3) begin
      chk("slow_req", {31'd0, imem_req}, 32'd1); step();
    end
    chk("slow_addr_held", imem_addr, 32'h8);
    do_fetch(0, 32'h1234_5678);
    chk("slow_instr", instr, 32'h1234_5678);
    do_exec(1, 1'b1, 32'h20, 32'h0);
    chk("to_0x20", imem_addr, 32'h20);
    do_fetch(1, 32'h0000_006F);
    do_exec(0, 1'b1, 32'h20, 32'hFFFF_FFF0);
    chk("jal_addr", imem_addr, 32'h10);
    do_fetch(0, 32'h0000_0067);
    do_exec(0, 1'b1, 32'h103, 32'h0);
    chk("jalr_addr", imem_addr, 32'h100);
    chk("jalr_trap", {31'd0, trap}, {31'd0, TRAP_EN});
    imem_ready = 1'b0; step();
    chk("trap_one_cycle", {31'd0, trap}, 32'd0);
    do_fetch(0, 32'h13);
    do_exec(0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    chk("to_top", imem_addr, 32'hFFFF_FFFC);
    do_fetch(2, 32'h13);
    do_exec(0, 1'b0, '0, '0);
    chk("wrap_addr", imem_addr, 32'h0);
    do_fetch(0, 32'h13);
    do_exec(0, 1'b0, '0, '0);
    imem_ready = 1'b0; step();
    reset = 1'b1; #1;
    chk("rst_fetch_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("rst_fetch_pc", instr_addr, RST_PC);
    reset = 1'b0; #1;
    chk("rst_fetch_rise", {31'd0, imem_req}, 32'd1);
    do_fetch(0, 32'hAAAA_5555);
    do_exec(0, 1'b0, '0, '0);
    do_fetch(0, 32'h5555_AAAA);
    reset = 1'b1; commit = 1'b1; branch_taken = 1'b1; branch_base = 32'h80; #1;
    chk("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("rst_exec_pc", instr_addr, RST_PC);
    chk("rst_exec_instr", instr, 32'h0);
    reset = 1'b0; commit = 1'b0; #1;
    chk("rst_exec_addr", imem_addr, RST_PC);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(39) == 0) begin
        reset = 1'b1; commit = 1'($urandom); imem_ready = 1'($urandom);
        repeat ($urandom_range(2, 1)) step();
        reset = 1'b0;
      end
      do_fetch(int'($urandom_range(3)), $urandom);
      do_exec(int'($urandom_range(3)), 1'($urandom), $urandom, $urandom_range(4095));
      if (TRAP_EN) begin
        imem_ready = 1'b0; step();
      end
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
